// File: rtl/fft_fifo_uart_top.sv
// fft_fifo_uart_top
//   Captures frames of a free-running 14-bit ramp into a FIFO and streams
//   each frame out over a UART (8N1) once the host grants it.
//
//   Flow: CAPTURE (one FIFO write per sample strobe, FRAME_LEN writes)
//         -> READY (tx_ready high, wait for rx_ready)
//         -> SEND (each sample as two bytes, sign-extended high byte first)
//         -> CAPTURE.
//
// Parameters
//   BAUD_DIV   clocks per UART bit
//   SAMPLE_DIV clocks between sample strobes (>= 2)
//   FRAME_LEN  samples per frame = FIFO depth (power of two, >= 2)
//   RAMP_INIT  ramp value loaded at reset (0 in normal use)
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset (released through two flops)
//   rx_ready  host grant, level-sensitive
//   tx_ready  registered: a full frame is buffered and awaits grant
//   tx        registered UART output, idle high
//
// Build option
//   FRAME_HEADER_EN  when defined, each frame starts with bytes 0xAA 0x55.
module fft_fifo_uart_top #(
   parameter int          BAUD_DIV   = 434,
   parameter int          SAMPLE_DIV = 50,
   parameter int          FRAME_LEN  = 64,
   parameter logic [13:0] RAMP_INIT  = 14'h0000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_ready,
   output logic tx_ready,
   output logic tx
);
   localparam int AW = $clog2(FRAME_LEN);
   localparam int SW = $clog2(SAMPLE_DIV);
   localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
`ifdef FRAME_HEADER_EN
   localparam int HDR = 2;
`else
   localparam int HDR = 0;
`endif
   localparam int NBYTES = 2 * FRAME_LEN + HDR;
   localparam int IW     = $clog2(NBYTES + 1);

   typedef enum logic [1:0] {CAPTURE, READY, SEND} state_t;

   state_t          state_q, state_d;
   logic [1:0]      rst_sync;
   logic            rst_s_n;
   logic [SW-1:0]   div_cnt;
   logic            strobe;
   logic [13:0]     ramp;
   logic [13:0]     mem [FRAME_LEN];
   logic [AW:0]     wr_ptr, rd_ptr, fill;
   logic            full, empty, wr_en, rd_en;
   logic [13:0]     head;
   logic [7:0]      cur_byte;
   logic            is_hdr;
   logic [IW-1:0]   byte_idx;
   logic [8:0]      shreg;
   logic [3:0]      bit_cnt;
   logic [BW-1:0]   baud_cnt;
   logic            busy, bit_end, byte_end, load;

   // Assert asynchronously, release after two clean clock edges.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   assign rst_s_n = rst_sync[1];

   // Sample strobe and ramp generator: free running, never stalled.
   assign strobe = (div_cnt == SW'(SAMPLE_DIV - 1));

   always_ff @(posedge clk or negedge rst_s_n)
      if (!rst_s_n) begin
         div_cnt <= '0;
         ramp    <= RAMP_INIT;
      end else begin
         div_cnt <= strobe ? '0 : div_cnt + SW'(1);
         if (strobe) ramp <= ramp + 14'd1;
      end

   // FIFO: pointers carry one extra bit so full and empty are distinct.
   assign fill  = wr_ptr - rd_ptr;
   assign full  = fill[AW];
   assign empty = (fill == '0);
   assign wr_en = strobe && (state_q == CAPTURE) && !full;
   assign rd_en = load && byte_idx[0] && !is_hdr && !empty;
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk)
      if (wr_en) mem[wr_ptr[AW-1:0]] <= ramp;

   always_ff @(posedge clk or negedge rst_s_n)
      if (!rst_s_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
      end

   // Byte selection: even index = sign-extended high byte, odd = low byte.
   // The head sample is popped when its low byte is loaded.
   always_comb begin
      is_hdr   = 1'b0;
      cur_byte = byte_idx[0] ? head[7:0] : {head[13], head[13], head[13:8]};
`ifdef FRAME_HEADER_EN
      if (byte_idx < IW'(HDR)) begin
         is_hdr   = 1'b1;
         cur_byte = byte_idx[0] ? 8'h55 : 8'hAA;
      end
`endif
   end

   // UART shifter. A new byte may load on the final clock of the previous
   // stop bit, which keeps bytes back-to-back.
   assign bit_end  = busy && (baud_cnt == BW'(BAUD_DIV - 1));
   assign byte_end = bit_end && (bit_cnt == 4'd9);
   assign load     = (state_q == SEND) && (byte_idx != IW'(NBYTES)) &&
                     (!busy || byte_end);

   always_ff @(posedge clk or negedge rst_s_n)
      if (!rst_s_n) begin
         tx       <= 1'b1;
         busy     <= 1'b0;
         shreg    <= '1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else if (load) begin
         tx       <= 1'b0;                 // start bit
         shreg    <= {1'b1, cur_byte};     // stop bit above the data
         busy     <= 1'b1;
         bit_cnt  <= '0;
         baud_cnt <= '0;
      end else if (busy) begin
         if (!bit_end) begin
            baud_cnt <= baud_cnt + BW'(1);
         end else if (byte_end) begin
            busy     <= 1'b0;
            tx       <= 1'b1;
            baud_cnt <= '0;
         end else begin
            tx       <= shreg[0];
            shreg    <= {1'b1, shreg[8:1]};
            bit_cnt  <= bit_cnt + 4'd1;
            baud_cnt <= '0;
         end
      end

   always_ff @(posedge clk or negedge rst_s_n)
      if (!rst_s_n)               byte_idx <= '0;
      else if (state_q != SEND)   byte_idx <= '0;
      else if (load)              byte_idx <= byte_idx + IW'(1);

   // Control FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         CAPTURE: if (strobe && fill == (AW+1)'(FRAME_LEN - 1)) state_d = READY;
         READY:   if (rx_ready) state_d = SEND;
         SEND:    if (byte_end && byte_idx == IW'(NBYTES)) state_d = CAPTURE;
         default: state_d = CAPTURE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_s_n)
      if (!rst_s_n) begin
         state_q  <= CAPTURE;
         tx_ready <= 1'b0;
      end else begin
         state_q  <= state_d;
         tx_ready <= (state_d == READY);
      end

endmodule

// File: tb/tb_fft_fifo_uart_top.sv
// tb_fft_fifo_uart_top
//   Directed bench: FRAME_LEN=4, SAMPLE_DIV=4, BAUD_DIV=4. A second instance
//   with the ramp preset to 0x1FFE covers the 0x1FFF -> 0x2000 wrap.
//   Expected bytes are hand-written tables; the header bytes are prepended
//   when FRAME_HEADER_EN is defined.
module tb_fft_fifo_uart_top;
   localparam int BD = 4, SD = 4, FL = 4;
`ifdef FRAME_HEADER_EN
   localparam int HB = 2;
`else
   localparam int HB = 0;
`endif
   localparam int NB = 2 * FL + HB;

   logic clk = 1'b0, rst_n = 1'b0, rx_ready = 1'b0, tx_ready, tx;
   logic rst_n_w = 1'b0, rx_ready_w = 1'b0, tx_ready_w, tx_w;
   int   cyc = 0, n_chk = 0, n_err = 0;

   logic [7:0] hdr_tab  [2] = '{8'hAA, 8'h55};
   logic [7:0] ramp_tab [8] = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};
   logic [7:0] wrap_tab [8] = '{8'h1F, 8'hFE, 8'h1F, 8'hFF, 8'hE0, 8'h00, 8'hE0, 8'h01};
   logic [7:0] rxb [NB];
   int         rxt [NB];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fft_fifo_uart_top #(.BAUD_DIV(BD), .SAMPLE_DIV(SD), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .tx_ready(tx_ready), .tx(tx));

   fft_fifo_uart_top #(.BAUD_DIV(BD), .SAMPLE_DIV(SD), .FRAME_LEN(FL),
                       .RAMP_INIT(14'h1FFE)) dut_w (
      .clk(clk), .rst_n(rst_n_w), .rx_ready(rx_ready_w), .tx_ready(tx_ready_w), .tx(tx_w));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic txv(input bit w);
      return w ? tx_w : tx;
   endfunction

   function automatic logic rdyv(input bit w);
      return w ? tx_ready_w : tx_ready;
   endfunction

   // Receive one byte, sampling mid-bit; ts = cycle of the start edge.
   task automatic rx_byte(input bit w, output logic [7:0] b, output int ts);
      int n = 0;
      b  = '0;
      ts = -1;
      @(negedge clk);
      while (txv(w) !== 1'b0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) begin
         chk("rx_timeout", 0, 1);
         return;
      end
      ts = cyc;
      repeat (BD / 2) @(negedge clk);
      chk("start_bit", txv(w), 0);
      for (int i = 0; i < 8; i++) begin
         repeat (BD) @(negedge clk);
         b[i] = txv(w);
      end
      repeat (BD) @(negedge clk);
      chk("stop_bit", txv(w), 1);
   endtask

   // Receive a whole frame; rx_ready of the chosen instance drops after byte 0.
   task automatic rx_frame(input bit w);
      for (int k = 0; k < NB; k++) begin
         rx_byte(w, rxb[k], rxt[k]);
         if (k == 0) begin
            if (w) rx_ready_w = 1'b0;
            else   rx_ready   = 1'b0;
         end
      end
      for (int k = 1; k < NB; k++)
         chk("byte_spacing", rxt[k] - rxt[k-1], 10 * BD);
   endtask

   function automatic logic [7:0] exp_byte(input bit wrap, input int k);
      if (k < HB) return hdr_tab[k];
      return wrap ? wrap_tab[k - HB] : ramp_tab[k - HB];
   endfunction

   // Wait (bounded) for tx_ready; n = clocks waited, quiet = tx stayed high.
   task automatic wait_rdy(input bit w, output int n, output bit quiet);
      n = 0;
      quiet = 1'b1;
      while (rdyv(w) !== 1'b1 && n < 200) begin
         @(negedge clk);
         if (txv(w) !== 1'b1) quiet = 1'b0;
         n++;
      end
      chk("rdy_timeout", n < 200, 1);
   endtask

   task automatic grant(input bit w, output int g);
      if (w) rx_ready_w = 1'b1;
      else   rx_ready   = 1'b1;
      g = cyc;
      @(negedge clk);
      chk("txr_drop", rdyv(w), 0);
   endtask

   initial begin
      int  n, g;
      bit  quiet;
      logic [7:0] lo0, lo;

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_txr", tx_ready, 0);
      chk("rst_tx_w", tx_w, 1);
      chk("rst_txr_w", tx_ready_w, 0);

      // First capture: tx_ready after roughly FRAME_LEN*SAMPLE_DIV clocks.
      rst_n = 1'b1;
      wait_rdy(0, n, quiet);
      chk("rdy_lat_min", n >= FL * SD, 1);
      chk("rdy_lat_max", n <= FL * SD + 4, 1);
      chk("idle_tx", quiet, 1);
      repeat (20) @(negedge clk);
      chk("hold_txr", tx_ready, 1);
      chk("hold_tx", tx, 1);

      // Frame 1: ramp 0..3, grant held then dropped mid-frame.
      grant(0, g);
      rx_frame(0);
      chk("start_lat", (rxt[0] - g) <= 2, 1);
      for (int k = 0; k < NB; k++) chk("frame1_byte", rxb[k], exp_byte(0, k));

      // Frame 2: one-clock grant pulse still sends the whole frame.
      wait_rdy(0, n, quiet);
      chk("rdy_again", tx_ready, 1);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      chk("pulse_txr_drop", tx_ready, 0);
      rx_frame(0);
      lo0 = rxb[HB + 1];
      for (int j = 1; j < FL; j++) begin
         lo = lo0 + 8'(j);
         chk("frame2_lo", rxb[HB + 2*j + 1], lo);
      end
      wait_rdy(0, n, quiet);
      chk("rdy_after_pulse", tx_ready, 1);

      // Reset in the middle of a byte.
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      n = 0;
      while (tx !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("mid_start_seen", n < 50, 1);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_txr", tx_ready, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_rdy(0, n, quiet);
      chk("post_rst_quiet", quiet, 1);
      grant(0, g);
      rx_frame(0);
      for (int k = 0; k < NB; k++) chk("restart_byte", rxb[k], exp_byte(0, k));

      // Wrap instance: samples 1FFE, 1FFF, 2000, 2001.
      @(negedge clk);
      rst_n_w = 1'b1;
      wait_rdy(1, n, quiet);
      chk("wrap_quiet", quiet, 1);
      grant(1, g);
      rx_frame(1);
      for (int k = 0; k < NB; k++) chk("wrap_byte", rxb[k], exp_byte(1, k));

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
